fc_per2apb: RTL and testbench

Peripheral-interconnect slave to APB master bridge for the fabric controller domain. It is the reverse direction of the existing APB-to-peripheral bridge that configures the FC HWPE. It accepts single req/gnt/r_valid transactions from the FC peripheral interconnect and issues one APB4 SETUP/ACCESS transfer per request. It returns read data and error status with the request ID.

---
 rtl/fc_per2apb.sv | 182 ++++++++++++++++++
 tb/tb_fc_per2apb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_per2apb.sv
// -----------------------------------------------------------------------------
// fc_per2apb
// Bridge from the FC peripheral interconnect (slave side) to an APB4 master.
// The bridge accepts one req/gnt transaction at a time and runs one APB
// SETUP/ACCESS transfer for it. The read data and the error status are
// returned on a one-cycle r_valid pulse, together with the request ID.
//
// Optional feature (macro FC_PER2APB_TIMEOUT_EN):
//   A wait-state counter aborts an ACCESS phase that has lasted
//   TIMEOUT_CYCLES cycles without pready_i. The aborted transfer is
//   answered with r_opc=1 and r_rdata=32'hDEAD_BEEF. When the macro is not
//   defined, ACCESS waits for pready_i without limit.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   per_slave_*_i         request side: req, add, we, wdata, be, id
//   per_slave_gnt_o       request accepted (combinational, IDLE only)
//   per_slave_r_*_o       response: valid, opc (1 = error), rdata, id
//   paddr_o .. penable_o  APB4 master outputs
//   prdata_i, pready_i,
//   pslverr_i             APB4 slave responses, sampled only in ACCESS
// -----------------------------------------------------------------------------
module fc_per2apb #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic [3:0]                pstrb_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic [31:0]               wdata_q;
  logic [3:0]                strb_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [31:0]               rdata_q;
  logic                      err_q;
  logic                      psel_q;
  logic                      penable_q;

  logic capture;
  logic complete;
  logic abort;
  logic timeout_hit;

`ifdef FC_PER2APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter is held at zero outside ACCESS, so it is clear on entry and
  // counts only the wait cycles of the current transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else if (!pready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // The wait cycle that would bring the count to TIMEOUT_CYCLES is the last
  // one allowed; pready_i in that cycle is handled first in the FSM.
  assign timeout_hit = (state_q == ACCESS) && !pready_i &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic and the combinational grant.
  always_comb begin
    state_d         = state_q;
    per_slave_gnt_o = 1'b0;
    capture         = 1'b0;
    complete        = 1'b0;
    abort           = 1'b0;
    case (state_q)
      IDLE: begin
        per_slave_gnt_o = per_slave_req_i;
        if (per_slave_req_i) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, request capture, response capture and the APB
  // psel/penable flops. psel/penable are driven from the next state so
  // they line up with SETUP/ACCESS without a combinational output path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      id_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q <= (state_d == ACCESS);
      if (capture) begin
        // The cast drops upper address bits or zero-extends as needed.
        addr_q  <= APB_ADDR_WIDTH'(per_slave_add_i);
        we_q    <= per_slave_we_i;
        wdata_q <= per_slave_wdata_i;
        strb_q  <= per_slave_we_i ? per_slave_be_i : 4'b0000;
        id_q    <= per_slave_id_i;
      end
      if (complete) begin
        rdata_q <= we_q ? 32'h0 : prdata_i;
        err_q   <= pslverr_i;
      end else if (abort) begin
        rdata_q <= 32'hDEAD_BEEF;
        err_q   <= 1'b1;
      end
    end
  end

  // Response fields are gated so they read as zero outside RESP.
  assign per_slave_r_valid_o = (state_q == RESP);
  assign per_slave_r_opc_o   = per_slave_r_valid_o ? err_q   : 1'b0;
  assign per_slave_r_rdata_o = per_slave_r_valid_o ? rdata_q : 32'h0;
  assign per_slave_r_id_o    = per_slave_r_valid_o ? id_q    : '0;

  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;
  assign pwrite_o  = we_q;
  assign pstrb_o   = strb_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;

endmodule

// File: tb/tb_fc_per2apb.sv
// -----------------------------------------------------------------------------
// tb_fc_per2apb
// Self-checking bench for fc_per2apb. Stimulus tasks drive requests and act
// as the APB slave; expected responses are queued at grant time and a
// separate monitor compares every r_valid pulse against the queue.
// Build with +define+FC_PER2APB_TIMEOUT_EN to exercise the timeout abort.
// -----------------------------------------------------------------------------
module tb_fc_per2apb;

  localparam int unsigned ID_W = 8;

  typedef struct packed {
    logic [31:0]     rdata;
    logic            opc;
    logic [ID_W-1:0] id;
  } resp_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            per_slave_req_i = 1'b0;
  logic [31:0]     per_slave_add_i = '0;
  logic            per_slave_we_i = 1'b0;
  logic [31:0]     per_slave_wdata_i = '0;
  logic [3:0]      per_slave_be_i = '0;
  logic [ID_W-1:0] per_slave_id_i = '0;
  logic            per_slave_gnt_o;
  logic            per_slave_r_valid_o;
  logic            per_slave_r_opc_o;
  logic [31:0]     per_slave_r_rdata_o;
  logic [ID_W-1:0] per_slave_r_id_o;
  logic [31:0]     paddr_o;
  logic [31:0]     pwdata_o;
  logic            pwrite_o;
  logic [3:0]      pstrb_o;
  logic            psel_o;
  logic            penable_o;
  logic [31:0]     prdata_i = '0;
  logic            pready_i = 1'b0;
  logic            pslverr_i = 1'b0;

  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  resp_t exp_q[$];

  fc_per2apb #(
    .APB_ADDR_WIDTH(32),
    .PER_ADDR_WIDTH(32),
    .ID_WIDTH      (ID_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .per_slave_req_i    (per_slave_req_i),
    .per_slave_add_i    (per_slave_add_i),
    .per_slave_we_i     (per_slave_we_i),
    .per_slave_wdata_i  (per_slave_wdata_i),
    .per_slave_be_i     (per_slave_be_i),
    .per_slave_id_i     (per_slave_id_i),
    .per_slave_gnt_o    (per_slave_gnt_o),
    .per_slave_r_valid_o(per_slave_r_valid_o),
    .per_slave_r_opc_o  (per_slave_r_opc_o),
    .per_slave_r_rdata_o(per_slave_r_rdata_o),
    .per_slave_r_id_o   (per_slave_r_id_o),
    .paddr_o            (paddr_o),
    .pwdata_o           (pwdata_o),
    .pwrite_o           (pwrite_o),
    .pstrb_o            (pstrb_o),
    .psel_o             (psel_o),
    .penable_o          (penable_o),
    .prdata_i           (prdata_i),
    .pready_i           (pready_i),
    .pslverr_i          (pslverr_i)
  );

  // Free-running clock and a cycle counter used for grant spacing.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expected
  // response; response fields must read as zero whenever r_valid is low.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (per_slave_r_valid_o) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_r_valid", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check_output("r_rdata", per_slave_r_rdata_o, e.rdata);
          check_output("r_opc", {31'd0, per_slave_r_opc_o}, {31'd0, e.opc});
          check_output("r_id", {24'd0, per_slave_r_id_o}, {24'd0, e.id});
        end
      end else begin
        check_output("idle_resp_fields",
                     per_slave_r_rdata_o | {31'd0, per_slave_r_opc_o} |
                     {24'd0, per_slave_r_id_o}, 32'd0);
      end
    end
  end

  // One complete transfer, entered just after a rising edge in IDLE. The
  // task plays the APB slave with 'waits' wait states and returns the cycle
  // of the grant. With 'hold' set, req stays high for the whole transfer.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [ID_W-1:0] id, input int waits,
                                input logic err, input logic [31:0] rd_val,
                                input logic hold, output int gnt_cyc);
    resp_t       e;
    logic [3:0]  exp_strb;
    exp_strb = we ? be : 4'b0000;
    per_slave_req_i   = 1'b1;
    per_slave_we_i    = we;
    per_slave_add_i   = addr;
    per_slave_wdata_i = wdata;
    per_slave_be_i    = be;
    per_slave_id_i    = id;
    @(negedge clk_i);
    check_output("gnt_in_idle", {31'd0, per_slave_gnt_o}, 32'd1);
    check_output("psel_before_setup", {31'd0, psel_o}, 32'd0);
    gnt_cyc = cyc;
    e.rdata = we ? 32'h0 : rd_val;
    e.opc   = err;
    e.id    = id;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    per_slave_req_i = hold;
    @(negedge clk_i);
    check_output("setup_psel_penable", {30'd0, psel_o, penable_o}, 32'd2);
    check_output("setup_gnt", {31'd0, per_slave_gnt_o}, 32'd0);
    check_output("setup_paddr", paddr_o, addr);
    check_output("setup_pwrite", {31'd0, pwrite_o}, {31'd0, we});
    check_output("setup_pstrb", {28'd0, pstrb_o}, {28'd0, exp_strb});
    check_output("setup_pwdata", pwdata_o, wdata);
    @(posedge clk_i); #1;
    for (int i = 0; i <= waits; i++) begin
      pready_i  = (i == waits);
      prdata_i  = pready_i ? rd_val : $urandom;
      pslverr_i = pready_i ? err : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check_output("access_psel_penable", {30'd0, psel_o, penable_o}, 32'd3);
      check_output("access_gnt", {31'd0, per_slave_gnt_o}, 32'd0);
      check_output("access_paddr", paddr_o, addr);
      check_output("access_pstrb", {28'd0, pstrb_o}, {28'd0, exp_strb});
      @(posedge clk_i); #1;
    end
    // Outside ACCESS the APB inputs carry junk that must be ignored.
    pready_i  = 1'($urandom_range(0, 1));
    prdata_i  = $urandom;
    pslverr_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check_output("resp_psel_penable", {30'd0, psel_o, penable_o}, 32'd0);
    check_output("resp_r_valid", {31'd0, per_slave_r_valid_o}, 32'd1);
    check_output("resp_gnt", {31'd0, per_slave_gnt_o}, 32'd0);
    @(posedge clk_i); #1;
    pready_i = 1'b0;
  endtask

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0, g1, n;
    resp_t e;
    $display("[TB] starting fc_per2apb bench");

    // Reset values.
    #2;
    @(negedge clk_i);
    check_output("reset_outputs",
                 {24'd0, per_slave_gnt_o, per_slave_r_valid_o, psel_o,
                  penable_o, pwrite_o, per_slave_r_opc_o, 2'b00}, 32'd0);
    check_output("reset_paddr", paddr_o, 32'd0);
    check_output("reset_pwdata", pwdata_o, 32'd0);
    check_output("reset_pstrb", {28'd0, pstrb_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed write, zero wait states.
    apply_stimulus(1'b1, 32'h1A10_0004, 32'hCAFE_F00D, 4'b0011, 8'd5, 0,
                   1'b0, 32'h5555_AAAA, 1'b0, g0);

    // Read with three wait states (penable high for four cycles).
    apply_stimulus(1'b0, 32'h1A10_0008, 32'h0, 4'b1111, 8'd6, 3,
                   1'b0, 32'h1234_5678, 1'b0, g0);

    // Read with slave error: opc set, data still returned.
    apply_stimulus(1'b0, 32'h1A10_000C, 32'h0, 4'b1111, 8'd7, 1,
                   1'b1, 32'h0BAD_F00D, 1'b0, g0);

    // Write with slave error: opc set, data zero.
    apply_stimulus(1'b1, 32'h1A10_0010, 32'h0123_4567, 4'b1000, 8'd8, 0,
                   1'b1, 32'hFFFF_FFFF, 1'b0, g0);

    // Back-to-back with req held: second grant four cycles after the first.
    apply_stimulus(1'b1, 32'h0000_0100, 32'h1111_1111, 4'b1111, 8'd1, 0,
                   1'b0, 32'h0, 1'b1, g0);
    apply_stimulus(1'b0, 32'h0000_0104, 32'h0, 4'b1111, 8'd2, 0,
                   1'b0, 32'h2222_2222, 1'b0, g1);
    check_output("b2b_grant_spacing", 32'(g1 - g0), 32'd4);

    // Reset asserted in the middle of ACCESS: abort without response.
    per_slave_req_i = 1'b1;
    per_slave_we_i  = 1'b0;
    per_slave_add_i = 32'h0000_0200;
    per_slave_id_i  = 8'd9;
    @(posedge clk_i); #1;
    per_slave_req_i = 1'b0;
    @(posedge clk_i); #1;
    pready_i = 1'b0;
    @(negedge clk_i);
    check_output("pre_reset_access", {30'd0, psel_o, penable_o}, 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("midreset_outputs",
                 {29'd0, psel_o, penable_o, per_slave_r_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    apply_stimulus(1'b0, 32'h0000_0204, 32'h0, 4'b1111, 8'd10, 2,
                   1'b0, 32'hA5A5_5A5A, 1'b0, g0);

    // ACCESS with pready never asserted.
    per_slave_req_i = 1'b1;
    per_slave_we_i  = 1'b0;
    per_slave_add_i = 32'h0000_0300;
    per_slave_id_i  = 8'd11;
    @(posedge clk_i); #1;
    per_slave_req_i = 1'b0;
    @(posedge clk_i); #1;
    pready_i = 1'b0;
`ifdef FC_PER2APB_TIMEOUT_EN
    e.rdata = 32'hDEAD_BEEF;
    e.opc   = 1'b1;
    e.id    = 8'd11;
    exp_q.push_back(e);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (psel_o && penable_o) n++;
      else break;
    end
    check_output("timeout_access_cycles", 32'(n), 32'd8);
    check_output("timeout_resp_valid",
                 {30'd0, psel_o, per_slave_r_valid_o}, 32'd1);
    @(posedge clk_i); #1;
`else
    n = 0;
    repeat (100) @(posedge clk_i);
    @(negedge clk_i);
    check_output("no_timeout_still_access", {30'd0, psel_o, penable_o}, 32'd3);
    e.rdata = 32'h7777_0000;
    e.opc   = 1'b0;
    e.id    = 8'd11;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    pready_i = 1'b1;
    prdata_i = 32'h7777_0000;
    pslverr_i = 1'b0;
    @(posedge clk_i); #1;
    pready_i = 1'b0;
    @(negedge clk_i);
    check_output("late_pready_resp", {31'd0, per_slave_r_valid_o}, 32'd1);
    @(posedge clk_i); #1;
`endif

    // Randomized transfers against the reference expectations.
    for (int t = 0; t < 24; t++) begin
      apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                     4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom, 1'b0, g0);
    end

    repeat (3) @(posedge clk_i);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
